pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised elastic pipeline register for inter-stage boundaries (if/id, id/ex, ex/mem, mem/wb); replaces per-field fixed DFF chains.
- Carries one packed payload word with a valid/ready handshake, so a stage can stall without losing data.
- Supports ctrl-driven flush with a programmable bubble value, and an optional 2-entry skid mode that registers in_ready to break the ready timing path.
- Exposes occupancy and a saturating stall counter for debug and perf.

Parameters:
DATA_W, 32, payload width in bits (≥1)
FLUSH_VALUE, {DATA_W{1'b0}}, payload value loaded on reset, flush, or drain to empty
SKID_EN, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
CNT_W, 16, stall counter width (≥1)

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk
flush_i  input  1  ctrl pipeline flush, active high
in_valid  input  1  upstream payload valid
in_ready  output  1  this stage can accept a payload
in_data  input  DATA_W  upstream payload
out_valid  output  1  payload available downstream
out_ready  input  1  downstream accepts a payload
out_data  output  DATA_W  payload to downstream; always driven from the main register
occ_o  output  2  entries held (0..2; max 1 when SKID_EN=0)
stall_cnt_o  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0

Behaviour:
- Events: accept = in_valid & in_ready; pop = out_valid & out_ready. in_data is sampled only on accept.
- Reset (rst_n=0 at a clock edge), taking priority over everything:
  - state EMPTY; main and skid <= FLUSH_VALUE; stall_cnt_o <= 0.
  - Outputs after reset: out_valid=0, occ_o=0, out_data=FLUSH_VALUE, in_ready=1.
- Flush (flush_i=1, rst_n=1), priority over all handshake events:
  - Next state EMPTY; main and skid <= FLUSH_VALUE; stall_cnt_o is unchanged.
  - in_ready is not gated by flush_i, so accept may still be true in the flush cycle. Any accept or pop in that cycle is void: data is discarded and no entry is retained.
  - Reset or flush mid-stall discards every held entry.
- SKID_EN=1: three states, with in_ready = (state != FULL) and out_valid = (state != EMPTY). in_ready is driven purely by a register.
  - EMPTY (occ 0):
    - accept -> HALF, main <= in_data.
  - HALF (occ 1):
    - accept & pop -> HALF, main <= in_data.
    - accept & !pop -> FULL, skid <= in_data.
    - !accept & pop -> EMPTY, main <= FLUSH_VALUE.
    - otherwise hold.
  - FULL (occ 2):
    - pop -> HALF, main <= skid, skid <= FLUSH_VALUE.
    - otherwise hold. No accept is possible in FULL.
  - Order is preserved: skid data always leaves after main.
- SKID_EN=0: one register; in_ready = out_ready | ~out_valid (combinational).
  - accept -> main <= in_data, valid <= 1.
  - pop & !accept -> main <= FLUSH_VALUE, valid <= 0.
  - otherwise hold. occ_o = {1'b0, valid}.
- Latency: 1 cycle from accept to out_valid when the stage was empty or popping in the same cycle. Throughput is 1 per cycle in both modes when out_ready is held at 1.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid stay constant. Upstream is not required to hold in_data once in_ready=0.
- Stall counter:
  - Increments on every cycle with out_valid & ~out_ready, including a flush cycle.
  - Saturates at all-ones and never wraps; cleared only by reset.
- Empty-drain rule: whenever the stage becomes EMPTY, out_data = FLUSH_VALUE. This keeps bubbles deterministic for downstream logic that does not qualify on out_valid.

Test Plan:
- Reset, SKID_EN=1, DATA_W=32: hold rst_n=0 for 2 cycles, then release -> out_valid=0, out_data=0x00000000, in_ready=1, occ_o=0, stall_cnt_o=0.
- Streaming: in_valid=1 with in_data 0x11,0x22,0x33 on consecutive cycles, out_ready=1 -> out_data 0x11,0x22,0x33 on cycles 1,2,3, in_ready never drops, occ_o=1 throughout.
- Backpressure and skid:
  - out_ready=0 while sending 0x11 then 0x22 -> occ_o=2 and in_ready=0 on the cycle after 0x22 is accepted.
  - stall_cnt_o=1 after the first blocked cycle.
  - Raising out_ready -> 0x11 then 0x22 delivered in order, then out_valid=0 and out_data=0.
- Flush while FULL (payload 0xAA main, 0xBB skid), with in_valid=1, in_data=0xCC in the flush cycle -> next cycle occ_o=0, out_valid=0, out_data=FLUSH_VALUE, in_ready=1; 0xCC is never output.
- SKID_EN=0, out_valid=1, out_ready=0, in_valid=1 -> in_ready=0 in the same cycle. Raising out_ready -> in_ready=1 combinationally, and the new payload appears the following cycle.
- Counter saturation, CNT_W=4: hold the stall for 20 cycles -> stall_cnt_o reaches 0xF and stays 0xF; a flush leaves it at 0xF; a reset clears it to 0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register carrying one payload word across a valid/ready boundary.
// Supports flush to a bubble value, an optional 2-entry skid buffer and a saturating stall counter.
//
// state    | meaning
// ---------+---------------------------------------------------
// ST_EMPTY | nothing held, out_data = FLUSH_VALUE
// ST_HALF  | main holds the next payload to leave
// ST_FULL  | main and skid both hold payloads (skid mode only)
module pipe_stage_reg #(
    parameter int unsigned          DATA_W      = 32,
    parameter logic [DATA_W-1:0]    FLUSH_VALUE = {DATA_W{1'b0}},
    parameter bit                   SKID_EN     = 1'b1,
    parameter int unsigned          CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occ_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             st;
    logic [DATA_W-1:0]  main_q;
    logic [DATA_W-1:0]  skid_q;
    logic               rdy_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               accept;
    logic               pop;

    assign out_valid   = (st != ST_EMPTY);
    assign out_data    = main_q;
    assign occ_o       = st;
    assign stall_cnt_o = cnt_q;
    // skid mode breaks the combinational ready path; plain mode lets ready pass through
    assign in_ready    = SKID_EN ? rdy_q : (out_ready | ~out_valid);
    assign accept      = in_valid & in_ready;
    assign pop         = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st     <= ST_EMPTY;
            main_q <= FLUSH_VALUE;
            skid_q <= FLUSH_VALUE;
            rdy_q  <= 1'b1;
            cnt_q  <= '0;
        end else begin
            if (out_valid && !out_ready && (cnt_q != {CNT_W{1'b1}}))
                cnt_q <= cnt_q + CNT_W'(1);

            if (flush_i) begin
                st     <= ST_EMPTY;
                main_q <= FLUSH_VALUE;
                skid_q <= FLUSH_VALUE;
                rdy_q  <= 1'b1;
            end else if (SKID_EN) begin
                case (st)
                    ST_EMPTY: begin
                        if (accept) begin
                            st     <= ST_HALF;
                            main_q <= in_data;
                        end
                    end
                    ST_HALF: begin
                        if (accept && pop) begin
                            main_q <= in_data;
                        end else if (accept) begin
                            st     <= ST_FULL;
                            skid_q <= in_data;
                            rdy_q  <= 1'b0;
                        end else if (pop) begin
                            st     <= ST_EMPTY;
                            main_q <= FLUSH_VALUE;
                        end
                    end
                    ST_FULL: begin
                        if (pop) begin
                            st     <= ST_HALF;
                            main_q <= skid_q;
                            skid_q <= FLUSH_VALUE;
                            rdy_q  <= 1'b1;
                        end
                    end
                    default: begin
                        st     <= ST_EMPTY;
                        main_q <= FLUSH_VALUE;
                        skid_q <= FLUSH_VALUE;
                        rdy_q  <= 1'b1;
                    end
                endcase
            end else begin
                if (accept) begin
                    st     <= ST_HALF;
                    main_q <= in_data;
                end else if (pop) begin
                    st     <= ST_EMPTY;
                    main_q <= FLUSH_VALUE;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid mode, plain mode and a narrow stall counter
// are exercised on three instances sharing one clock.
module tb_pipe_stage_reg;

    logic clk;
    logic rst_n;
    logic rst_c;
    int   checks;
    int   errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // instance a: skid mode, 32-bit, zero bubble
    logic        a_flush, a_iv, a_ir, a_ov, a_or;
    logic [31:0] a_id, a_od;
    logic [1:0]  a_occ;
    logic [15:0] a_cnt;

    pipe_stage_reg #(.DATA_W(32), .SKID_EN(1'b1), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush_i(a_flush),
        .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
        .out_valid(a_ov), .out_ready(a_or), .out_data(a_od),
        .occ_o(a_occ), .stall_cnt_o(a_cnt)
    );

    // instance b: single register, combinational ready
    logic        b_flush, b_iv, b_ir, b_ov, b_or;
    logic [7:0]  b_id, b_od;
    logic [1:0]  b_occ;
    logic [15:0] b_cnt;

    pipe_stage_reg #(.DATA_W(8), .SKID_EN(1'b0), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush_i(b_flush),
        .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
        .out_valid(b_ov), .out_ready(b_or), .out_data(b_od),
        .occ_o(b_occ), .stall_cnt_o(b_cnt)
    );

    // instance c: 4-bit stall counter, non-zero bubble
    logic        c_flush, c_iv, c_ir, c_ov, c_or;
    logic [7:0]  c_id, c_od;
    logic [1:0]  c_occ;
    logic [3:0]  c_cnt;

    pipe_stage_reg #(.DATA_W(8), .FLUSH_VALUE(8'h5A), .SKID_EN(1'b1), .CNT_W(4)) dut_c (
        .clk(clk), .rst_n(rst_c), .flush_i(c_flush),
        .in_valid(c_iv), .in_ready(c_ir), .in_data(c_id),
        .out_valid(c_ov), .out_ready(c_or), .out_data(c_od),
        .occ_o(c_occ), .stall_cnt_o(c_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    logic [31:0] stream_v [3];

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0; rst_c = 1'b0;
        a_flush = 0; a_iv = 0; a_id = '0; a_or = 0;
        b_flush = 0; b_iv = 0; b_id = '0; b_or = 0;
        c_flush = 0; c_iv = 0; c_id = '0; c_or = 0;

        repeat (2) @(negedge clk);
        rst_n = 1'b1; rst_c = 1'b1;
        #1;
        chk("rst_ov",   a_ov,  0);
        chk("rst_od",   a_od,  32'h0);
        chk("rst_ir",   a_ir,  1);
        chk("rst_occ",  a_occ, 0);
        chk("rst_cnt",  a_cnt, 0);
        chk("rst_c_od", c_od,  8'h5A);

        // streaming with out_ready held high
        stream_v[0] = 32'h11; stream_v[1] = 32'h22; stream_v[2] = 32'h33;
        a_or = 1; a_iv = 1; a_id = stream_v[0];
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("str_od",  a_od,  stream_v[i]);
            chk("str_ov",  a_ov,  1);
            chk("str_ir",  a_ir,  1);
            chk("str_occ", a_occ, 1);
            if (i < 2) a_id = stream_v[i+1];
            else a_iv = 0;
        end
        @(negedge clk);
        chk("str_end_ov", a_ov, 0);
        chk("str_end_od", a_od, 32'h0);

        // backpressure fills the skid entry
        a_or = 0; a_iv = 1; a_id = 32'h11;
        @(negedge clk);
        chk("bp_cnt0", a_cnt, 0);
        a_id = 32'h22;
        @(negedge clk);
        chk("bp_occ", a_occ, 2);
        chk("bp_ir",  a_ir,  0);
        chk("bp_cnt", a_cnt, 1);
        chk("bp_od",  a_od,  32'h11);
        a_iv = 0; a_or = 1;
        @(negedge clk);
        chk("bp_od2",  a_od,  32'h22);
        chk("bp_occ2", a_occ, 1);
        chk("bp_ir2",  a_ir,  1);
        @(negedge clk);
        chk("bp_drain_ov", a_ov, 0);
        chk("bp_drain_od", a_od, 32'h0);
        chk("bp_drain_cnt", a_cnt, 1);

        // flush while full with a new payload offered in the same cycle
        a_or = 0; a_iv = 1; a_id = 32'hAA;
        @(negedge clk);
        a_id = 32'hBB;
        @(negedge clk);
        chk("fl_pre_occ", a_occ, 2);
        chk("fl_pre_od",  a_od,  32'hAA);
        a_flush = 1; a_id = 32'hCC;
        @(negedge clk);
        chk("fl_occ", a_occ, 0);
        chk("fl_ov",  a_ov,  0);
        chk("fl_od",  a_od,  32'h0);
        chk("fl_ir",  a_ir,  1);
        chk("fl_cnt", a_cnt, 3);
        a_flush = 0; a_iv = 0; a_or = 1;
        repeat (2) begin
            @(negedge clk);
            chk("fl_after_ov", a_ov, 0);
        end

        // plain mode: combinational ready
        b_iv = 1; b_id = 8'h44; b_or = 0;
        #1 chk("b_ir_empty", b_ir, 1);
        @(negedge clk);
        b_id = 8'h55;
        #1;
        chk("b_ir_stall", b_ir,  0);
        chk("b_ov",       b_ov,  1);
        chk("b_occ",      b_occ, 1);
        chk("b_od",       b_od,  8'h44);
        @(negedge clk);
        chk("b_hold_od", b_od, 8'h44);
        b_or = 1;
        #1 chk("b_ir_comb", b_ir, 1);
        @(negedge clk);
        chk("b_od_new", b_od, 8'h55);
        chk("b_ov_new", b_ov, 1);
        b_iv = 0;
        @(negedge clk);
        chk("b_end_ov",  b_ov,  0);
        chk("b_end_od",  b_od,  8'h00);
        chk("b_end_occ", b_occ, 0);

        // counter saturation on the 4-bit instance
        c_iv = 1; c_id = 8'h77; c_or = 0;
        @(negedge clk);
        c_iv = 0;
        chk("c_od", c_od, 8'h77);
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            chk("c_sat", c_cnt, (j > 15) ? 32'd15 : 32'(j));
        end
        chk("c_hold_od", c_od, 8'h77);
        c_flush = 1;
        @(negedge clk);
        c_flush = 0;
        chk("c_fl_cnt", c_cnt, 4'hF);
        chk("c_fl_od",  c_od,  8'h5A);
        chk("c_fl_ov",  c_ov,  0);
        rst_c = 0;
        @(negedge clk);
        rst_c = 1;
        chk("c_rst_cnt", c_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
